npu_sram_dp: RTL and testbench
==============================

NPU_SRAM_DP -- requirements
Module: npu_sram_dp

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits; legal values are multiples of 8.
REQ-002 SHALL provide parameter ADDR_W, default 14, word-address width; depth is 2^ADDR_W words.
REQ-003 SHALL provide parameter READ_LATENCY, default 1, cycles from accepted read to readdatavalid; legal range 1..3.
REQ-004 SHALL provide parameter INIT_CLEAR, default 1; when 1, memory is zero-filled after every reset.
REQ-005 SHALL derive BE_W = DATA_W/8 internally.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, ports as follows: clk  in  1  sole clock, all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 For x in {a,b}: address_x  in  ADDR_W  word address.
REQ-009 byteenable_x  in  BE_W  byte-lane write mask.
REQ-010 chipselect_x, read_x, write_x  in  1 each  Avalon-MM request qualifiers.
REQ-011 writedata_x  in  DATA_W  write data.
REQ-012 clken_x  in  1  port clock enable; low freezes that port.
REQ-013 readdata_x  out  DATA_W  read data.
REQ-014 readdatavalid_x  out  1  one-cycle qualifier for readdata_x.
REQ-015 waitrequest_x  out  1  request not accepted this cycle.
REQ-016 clear_req  in  1  single-cycle pulse requesting a zero-fill.
REQ-017 init_busy  out  1  high while a zero-fill is in progress.

Function
REQ-018 SHALL implement FSM states CLEAR and RUN; after reset, INIT_CLEAR=1 -> CLEAR, INIT_CLEAR=0 -> RUN.
REQ-019 In CLEAR, SHALL write all-zero to one address per cycle, counting 0 to 2^ADDR_W-1, then enter RUN the next cycle; the counter SHALL NOT wrap past the last address.
REQ-020 init_busy SHALL equal (state==CLEAR).
REQ-021 clear_req in RUN SHALL enter CLEAR with counter 0 the next cycle; clear_req in CLEAR SHALL be ignored.
REQ-022 waitrequest_x SHALL equal init_busy | ~clken_x.
REQ-023 A request is accepted when chipselect_x & (read_x | write_x) & ~waitrequest_x.
REQ-024 An accepted write SHALL update only lanes with byteenable_x set, visible to reads accepted on the following cycle.
REQ-025 read_x and write_x both high SHALL be treated as a write only, with no readdatavalid.
REQ-026 An accepted read SHALL produce readdata_x with readdatavalid_x high exactly READ_LATENCY enabled cycles later; back-to-back reads SHALL be accepted every cycle.
REQ-027 readdata_x SHALL hold its last value when readdatavalid_x is low.
REQ-028 clken_x low SHALL freeze port x's read pipeline, holding readdata_x and readdatavalid_x; the pipeline resumes when clken_x returns high.
REQ-029 A read in the pipeline when CLEAR is entered SHALL complete with the data sampled at acceptance.
REQ-030 Same-cycle writes from both ports to one address: per byte lane, port A wins where both lanes are enabled; B-only lanes SHALL take B data.
REQ-031 A read on one port and a write on the other to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-032 A same-port write followed by a read of that address on the next cycle SHALL return the new data.

Reset
REQ-033 reset_n low SHALL asynchronously clear readdatavalid_a/b, readdata_a/b, the read pipelines and the clear counter, and set the FSM per REQ-018.
REQ-034 Memory contents SHALL NOT be reset except through CLEAR; reset asserted mid-CLEAR SHALL restart the fill at address 0.

Verification (DATA_W=16, ADDR_W=4, READ_LATENCY=2, INIT_CLEAR=1)
REQ-035 Release reset -> init_busy and waitrequest_a/b high for 16 cycles; afterwards reads of all 16 addresses return 0x0000.
REQ-036 Port A writes 0xBEEF to address 3, then reads 3 on the next cycle -> readdatavalid_a high 2 cycles after the read with readdata_a=0xBEEF; with 0x1234 written using byteenable 2'b01, a read returns 0xBE34.
REQ-037 Same cycle: A writes 0xAAAA be=2'b11 and B writes 0x5555 be=2'b10 to address 5 -> address 5 reads 0xAAAA; repeat with A be=2'b01 -> 0x55AA.
REQ-038 Address 7 holds 0x1111; same cycle A reads 7 while B writes 0x2222 -> readdata_a=0x1111; a later read returns 0x2222.
REQ-039 Four back-to-back A reads with clken_a dropped for 3 cycles after the second -> four valid pulses in order, output and valid held during the stall, no loss or duplication.
REQ-040 clear_req with a read outstanding -> the read returns pre-clear data; init_busy is high 16 cycles; memory is then all zero; reset_n pulsed mid-clear restarts the fill at address 0.

Source files
------------

// File: rtl/npu_sram_dp.sv
// rtl/npu_sram_dp.sv - dual-port byte-maskable SRAM with zero-fill engine
//
// Ports (x in {a,b}):
//   clk, reset_n            sole clock (rising edge), async active-low reset
//   address_x   [ADDR_W]    word address
//   byteenable_x[BE_W]      byte-lane write mask
//   chipselect_x            request qualifier
//   read_x, write_x         request type (both high = write only)
//   writedata_x [DATA_W]    write data
//   clken_x                 port clock enable, low freezes the port
//   readdata_x  [DATA_W]    read data, holds between valid pulses
//   readdatavalid_x         one-cycle qualifier for readdata_x
//   waitrequest_x           request not accepted this cycle
//   clear_req               pulse requesting a zero-fill of the whole array
//   init_busy               zero-fill in progress

module npu_sram_dp #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned INIT_CLEAR   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    address_a,
  input  logic [DATA_W/8-1:0]  byteenable_a,
  input  logic                 chipselect_a,
  input  logic                 read_a,
  input  logic                 write_a,
  input  logic [DATA_W-1:0]    writedata_a,
  input  logic                 clken_a,
  output logic [DATA_W-1:0]    readdata_a,
  output logic                 readdatavalid_a,
  output logic                 waitrequest_a,
  input  logic [ADDR_W-1:0]    address_b,
  input  logic [DATA_W/8-1:0]  byteenable_b,
  input  logic                 chipselect_b,
  input  logic                 read_b,
  input  logic                 write_b,
  input  logic [DATA_W-1:0]    writedata_b,
  input  logic                 clken_b,
  output logic [DATA_W-1:0]    readdata_b,
  output logic                 readdatavalid_b,
  output logic                 waitrequest_b,
  input  logic                 clear_req,
  output logic                 init_busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;

  // Storage array; only the zero-fill engine ever initialises it.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Index 0 is port A, index 1 is port B, so both ports share one code path.
  logic [ADDR_W-1:0] p_addr  [2];
  logic [BE_W-1:0]   p_be    [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic [1:0]        p_cs, p_rd, p_wr, p_clken, p_wait;
  logic [1:0]        wr_acc, rd_acc;

  // Read pipeline: stage 0 captures the array word at acceptance, the last
  // stage drives the port outputs. Data stages load only behind a valid so
  // the output word holds its last value through bubbles.
  logic [DATA_W-1:0]       rd_data_q [2][READ_LATENCY];
  logic [DATA_W-1:0]       rd_data_d [2][READ_LATENCY];
  logic [READ_LATENCY-1:0] rd_vld_q  [2];
  logic [READ_LATENCY-1:0] rd_vld_d  [2];

  assign p_addr[0]  = address_a;
  assign p_addr[1]  = address_b;
  assign p_be[0]    = byteenable_a;
  assign p_be[1]    = byteenable_b;
  assign p_wdata[0] = writedata_a;
  assign p_wdata[1] = writedata_b;
  assign p_cs       = {chipselect_b, chipselect_a};
  assign p_rd       = {read_b, read_a};
  assign p_wr       = {write_b, write_a};
  assign p_clken    = {clken_b, clken_a};

  assign init_busy = (state_q == S_CLEAR);
  assign p_wait    = {2{init_busy}} | ~p_clken;

  // Write has priority over read when both are asserted together.
  assign wr_acc = p_cs & p_wr & ~p_wait;
  assign rd_acc = p_cs & p_rd & ~p_wr & ~p_wait;

  assign waitrequest_a   = p_wait[0];
  assign waitrequest_b   = p_wait[1];
  assign readdata_a      = rd_data_q[0][READ_LATENCY-1];
  assign readdata_b      = rd_data_q[1][READ_LATENCY-1];
  assign readdatavalid_a = rd_vld_q[0][READ_LATENCY-1];
  assign readdatavalid_b = rd_vld_q[1][READ_LATENCY-1];

  // Zero-fill sequencer. The counter parks on the last address rather than
  // wrapping; a new fill always restarts it from zero.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      S_RUN: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  // Read pipelines advance only on enabled cycles. The array is sampled
  // before this edge's writes land, giving read-before-write across ports.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_vld_d[p] = rd_vld_q[p];
      for (int s = 0; s < READ_LATENCY; s++) begin
        rd_data_d[p][s] = rd_data_q[p][s];
      end
      if (p_clken[p]) begin
        rd_vld_d[p][0] = rd_acc[p];
        if (rd_acc[p]) begin
          rd_data_d[p][0] = mem[p_addr[p]];
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
          rd_vld_d[p][s] = rd_vld_q[p][s-1];
          if (rd_vld_q[p][s-1]) begin
            rd_data_d[p][s] = rd_data_q[p][s-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      for (int p = 0; p < 2; p++) begin
        rd_vld_q[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
          rd_data_q[p][s] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      for (int p = 0; p < 2; p++) begin
        rd_vld_q[p] <= rd_vld_d[p];
        for (int s = 0; s < READ_LATENCY; s++) begin
          rd_data_q[p][s] <= rd_data_d[p][s];
        end
      end
    end
  end

  // Array writes. Port B lanes are applied first so that port A overrides
  // any lane both ports enable at the same address. No request is accepted
  // while filling, so the fill write never collides with a port write.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_cnt_q] <= '0;
    end
    for (int l = 0; l < BE_W; l++) begin
      if (wr_acc[1] && p_be[1][l]) begin
        mem[p_addr[1]][8*l +: 8] <= p_wdata[1][8*l +: 8];
      end
      if (wr_acc[0] && p_be[0][l]) begin
        mem[p_addr[0]][8*l +: 8] <= p_wdata[0][8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_npu_sram_dp.sv
// tb/tb_npu_sram_dp.sv - directed self-checking bench for npu_sram_dp

module tb_npu_sram_dp;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address_a, address_b;
  logic [1:0]    byteenable_a, byteenable_b;
  logic          chipselect_a, chipselect_b;
  logic          read_a, read_b, write_a, write_b;
  logic [DW-1:0] writedata_a, writedata_b;
  logic          clken_a, clken_b;
  logic [DW-1:0] readdata_a, readdata_b;
  logic          readdatavalid_a, readdatavalid_b;
  logic          waitrequest_a, waitrequest_b;
  logic          clear_req;
  logic          init_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npu_sram_dp #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .address_a(address_a), .byteenable_a(byteenable_a), .chipselect_a(chipselect_a),
    .read_a(read_a), .write_a(write_a), .writedata_a(writedata_a), .clken_a(clken_a),
    .readdata_a(readdata_a), .readdatavalid_a(readdatavalid_a), .waitrequest_a(waitrequest_a),
    .address_b(address_b), .byteenable_b(byteenable_b), .chipselect_b(chipselect_b),
    .read_b(read_b), .write_b(write_b), .writedata_b(writedata_b), .clken_b(clken_b),
    .readdata_b(readdata_b), .readdatavalid_b(readdatavalid_b), .waitrequest_b(waitrequest_b),
    .clear_req(clear_req), .init_busy(init_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fill_val(input int i);
    return 16'hA500 + 16'(i) * 16'h0101;
  endfunction

  task automatic idle_ports();
    chipselect_a = 1'b0; read_a = 1'b0; write_a = 1'b0;
    chipselect_b = 1'b0; read_b = 1'b0; write_b = 1'b0;
  endtask

  task automatic drive_write(input bit port, input logic [3:0] addr,
                             input logic [15:0] data, input logic [1:0] be);
    if (port == 1'b0) begin
      chipselect_a = 1'b1; write_a = 1'b1; read_a = 1'b0;
      address_a = addr; writedata_a = data; byteenable_a = be;
    end else begin
      chipselect_b = 1'b1; write_b = 1'b1; read_b = 1'b0;
      address_b = addr; writedata_b = data; byteenable_b = be;
    end
  endtask

  task automatic write_word(input bit port, input logic [3:0] addr,
                            input logic [15:0] data, input logic [1:0] be);
    drive_write(port, addr, data, be);
    @(negedge clk);
    idle_ports();
  endtask

  task automatic issue_read_a(input logic [3:0] addr);
    chipselect_a = 1'b1; read_a = 1'b1; write_a = 1'b0; address_a = addr;
  endtask

  task automatic wait_read_a(output logic [15:0] data, output int lat);
    @(negedge clk);
    idle_ports();
    lat = 1;
    while (!readdatavalid_a && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("rd_valid_seen", readdatavalid_a, 1);
    data = readdata_a;
  endtask

  task automatic read_a_word(input logic [3:0] addr, output logic [15:0] data, output int lat);
    issue_read_a(addr);
    wait_read_a(data, lat);
  endtask

  task automatic count_busy(input bit poke, output int n);
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      clear_req = poke && (n == 5);
      @(negedge clk);
    end
    clear_req = 1'b0;
  endtask

  bit        rd_tab [12] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  bit        ce_tab [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  logic [3:0] ad_tab [12] = '{4'd8, 4'd9, 4'd0, 4'd0, 4'd0, 4'd10, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] got_q [$];
    int          lat;
    int          n;

    reset_n = 1'b0; clear_req = 1'b0;
    clken_a = 1'b1; clken_b = 1'b1;
    address_a = '0; address_b = '0; byteenable_a = 2'b11; byteenable_b = 2'b11;
    writedata_a = '0; writedata_b = '0;
    idle_ports();
    repeat (3) @(negedge clk);

    check("rst_busy", init_busy, 1);
    check("rst_valid_a", readdatavalid_a, 0);
    check("rst_rdata_a", readdata_a, 0);
    check("rst_wait_b", waitrequest_b, 1);

    reset_n = 1'b1;
    count_busy(1'b0, n);
    check("init_busy_cycles", n, 16);
    check("wait_a_after_init", waitrequest_a, 0);

    for (int i = 0; i < 16; i++) begin
      read_a_word(4'(i), d, lat);
      check($sformatf("init_zero_%0d", i), d, 16'h0000);
    end

    write_word(1'b0, 4'd3, 16'hBEEF, 2'b11);
    read_a_word(4'd3, d, lat);
    check("wr_then_rd", d, 16'hBEEF);
    check("rd_latency", lat, RL);
    @(negedge clk);
    check("valid_one_cycle", readdatavalid_a, 0);
    check("rdata_hold", readdata_a, 16'hBEEF);
    write_word(1'b0, 4'd3, 16'h1234, 2'b01);
    read_a_word(4'd3, d, lat);
    check("byte_mask", d, 16'hBE34);

    drive_write(1'b0, 4'd5, 16'hAAAA, 2'b11);
    drive_write(1'b1, 4'd5, 16'h5555, 2'b10);
    @(negedge clk);
    idle_ports();
    read_a_word(4'd5, d, lat);
    check("collide_a_full", d, 16'hAAAA);
    drive_write(1'b0, 4'd5, 16'hAAAA, 2'b01);
    drive_write(1'b1, 4'd5, 16'h5555, 2'b10);
    @(negedge clk);
    idle_ports();
    read_a_word(4'd5, d, lat);
    check("collide_lane_mix", d, 16'h55AA);

    write_word(1'b0, 4'd7, 16'h1111, 2'b11);
    issue_read_a(4'd7);
    drive_write(1'b1, 4'd7, 16'h2222, 2'b11);
    wait_read_a(d, lat);
    check("rbw_old_data", d, 16'h1111);
    read_a_word(4'd7, d, lat);
    check("rbw_new_data", d, 16'h2222);

    chipselect_b = 1'b1; read_b = 1'b1; address_b = 4'd7;
    @(negedge clk);
    idle_ports();
    n = 1;
    while (!readdatavalid_b && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b_rd_valid", readdatavalid_b, 1);
    check("b_rd_data", readdata_b, 16'h2222);
    check("b_rd_latency", n, RL);

    for (int i = 0; i < 16; i++) write_word(1'b0, 4'(i), fill_val(i), 2'b11);

    for (int k = 0; k < 12; k++) begin
      chipselect_a = rd_tab[k]; read_a = rd_tab[k];
      address_a = ad_tab[k]; clken_a = ce_tab[k];
      #1;
      if (readdatavalid_a && clken_a) got_q.push_back(readdata_a);
      if (k == 3) begin
        check("stall_valid_held", readdatavalid_a, 1);
        check("stall_data_held", readdata_a, fill_val(8));
      end
      @(negedge clk);
    end
    idle_ports();
    clken_a = 1'b1;
    check("stall_count", got_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("stall_order_%0d", j),
            (j < got_q.size()) ? {16'h0, got_q[j]} : 32'hDEAD0000, fill_val(8 + j));
    end

    issue_read_a(4'd3);
    @(negedge clk);
    idle_ports();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("preclear_valid", readdatavalid_a, 1);
    check("preclear_data", readdata_a, fill_val(3));
    check("clear_wait_b", waitrequest_b, 1);
    count_busy(1'b1, n);
    check("clear_busy_cycles", n, 16);
    for (int i = 0; i < 16; i++) begin
      read_a_word(4'(i), d, lat);
      check($sformatf("clear_zero_%0d", i), d, 16'h0000);
    end

    for (int i = 0; i < 16; i++) write_word(1'b0, 4'(i), fill_val(i), 2'b11);
    read_a_word(4'd5, d, lat);
    check("pre_reset_rd", d, fill_val(5));
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midclr_rst_busy", init_busy, 1);
    check("midclr_rst_rdata", readdata_a, 0);
    check("midclr_rst_valid", readdatavalid_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(1'b0, n);
    check("restart_busy_cycles", n, 16);
    read_a_word(4'd0, d, lat);
    check("restart_zero_0", d, 16'h0000);
    read_a_word(4'd8, d, lat);
    check("restart_zero_8", d, 16'h0000);
    read_a_word(4'd15, d, lat);
    check("restart_zero_15", d, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
